// File: rtl/cmd_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sched_pkg
// Brief    : Shared encodings for the command scheduler (parser/arbiter
//            states, command byte layout, response header).
// Revision : 1.0
// ============================================================================
package cmd_sched_pkg;

    localparam logic [1:0] P_CMD  = 2'd0;
    localparam logic [1:0] P_DATA = 2'd1;
    localparam logic [1:0] P_WAIT = 2'd2;

    localparam logic [2:0] T_IDLE = 3'd0;
    localparam logic [2:0] T_RSP0 = 3'd1;
    localparam logic [2:0] T_RSP1 = 3'd2;
    localparam logic [2:0] T_PIX0 = 3'd3;
    localparam logic [2:0] T_PIX1 = 3'd4;

    localparam logic [7:0] RSP_HDR   = 8'hA0;
    localparam logic [3:0] CTRL_ADDR = 4'd0;

    localparam int CMD_WR_BIT      = 7;
    localparam int CMD_RSV_MSB     = 6;
    localparam int CMD_RSV_LSB     = 4;
    localparam int CMD_ADDR_MSB    = 3;
    localparam int CMD_ADDR_LSB    = 0;
    localparam int CTRL_PIX_EN_BIT = 0;

    typedef struct packed {
        logic       wr;
        logic [2:0] rsv;
        logic [3:0] addr;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [7:0] b);
        cmd_t c;
        c.wr   = b[CMD_WR_BIT];
        c.rsv  = b[CMD_RSV_MSB:CMD_RSV_LSB];
        c.addr = b[CMD_ADDR_MSB:CMD_ADDR_LSB];
        return c;
    endfunction

    function automatic logic [7:0] rsp_header(input logic [3:0] addr);
        return RSP_HDR | {4'h0, addr};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sched_if
// Brief    : FIFO, register-bus and pixel-stream signals of the scheduler.
// Revision : 1.0
// ============================================================================
interface cmd_sched_if;

    logic [7:0]  rx_rdata;
    logic        rx_rempty;
    logic        rx_rinc;
    logic [7:0]  tx_wdata;
    logic        tx_wfull;
    logic        tx_winc;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic [7:0]  reg_rdata;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_en;
    logic        cmd_err;

    // master = scheduler side, slave = FIFOs / register file / CCD side
    modport master (
        input  rx_rdata, rx_rempty, tx_wfull, reg_rdata, pix_data, pix_valid,
        output rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we,
        output pix_ready, pix_en, cmd_err
    );

    modport slave (
        output rx_rdata, rx_rempty, tx_wfull, reg_rdata, pix_data, pix_valid,
        input  rx_rinc, tx_wdata, tx_winc, reg_addr, reg_wdata, reg_we,
        input  pix_ready, pix_en, cmd_err
    );

endinterface
`default_nettype wire

// File: rtl/cmd_sched_parse.sv
`default_nettype none
// ============================================================================
// Module   : cmd_parse
// Brief    : Host command parser: decodes read/write commands from the rx
//            FIFO, drives the register bus and holds pending read data.
// Revision : 1.0
// ============================================================================
module cmd_parse
    import cmd_sched_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [7:0] i_rx_rdata,
    input  wire logic       i_rx_rempty,
    output logic            o_rx_rinc,
    input  wire logic [7:0] i_ctrl,
    input  wire logic [7:0] i_reg_rdata,
    input  wire logic       i_rsp_done,
    output logic [3:0]      o_reg_addr,
    output logic [7:0]      o_reg_wdata,
    output logic            o_reg_we,
    output logic            o_ctrl_we,
    output logic [7:0]      o_ctrl_wdata,
    output logic            o_rsp_pend,
    output logic [3:0]      o_rsp_addr,
    output logic [7:0]      o_rsp_data,
    output logic            o_cmd_err
);

    logic [1:0] r_state;
    logic [3:0] r_addr;
    logic [3:0] r_reg_addr;
    logic [7:0] r_reg_wdata;
    logic       r_reg_we;
    logic       r_rsp_pend;
    logic [7:0] r_rsp_data;
    logic       r_rd_cap;
    logic       r_cmd_err;

    logic       w_pop;
    cmd_t       w_cmd;

    // rst gating keeps the pop strobe quiet while the FIFO may still be non-empty
    assign w_pop = ~rst & ~i_rx_rempty
                 & ((r_state == P_CMD) | (r_state == P_DATA))
                 & ~((r_state == P_CMD) & r_rsp_pend);
    assign w_cmd = decode_cmd(i_rx_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= P_CMD;
            r_addr      <= 4'h0;
            r_reg_addr  <= 4'h0;
            r_reg_wdata <= 8'h00;
            r_reg_we    <= 1'b0;
            r_rsp_pend  <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_rd_cap    <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_reg_we  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rd_cap  <= 1'b0;
            // reg_addr was set on the pop edge, so reg_rdata is valid now
            if (r_rd_cap)
                r_rsp_data <= (r_addr == CTRL_ADDR) ? i_ctrl : i_reg_rdata;
            case (r_state)
                P_CMD: begin
                    if (w_pop) begin
                        if (w_cmd.rsv != 3'b000) begin
                            r_cmd_err <= 1'b1;
                        end else if (w_cmd.wr) begin
                            r_addr  <= w_cmd.addr;
                            r_state <= P_DATA;
                        end else begin
                            r_addr     <= w_cmd.addr;
                            r_reg_addr <= w_cmd.addr;
                            r_rsp_pend <= 1'b1;
                            r_rd_cap   <= 1'b1;
                            r_state    <= P_WAIT;
                        end
                    end
                end
                P_DATA: begin
                    if (w_pop) begin
                        if (r_addr != CTRL_ADDR) begin
                            r_reg_addr  <= r_addr;
                            r_reg_wdata <= i_rx_rdata;
                            r_reg_we    <= 1'b1;
                        end
                        r_state <= P_CMD;
                    end
                end
                P_WAIT: begin
                    if (i_rsp_done) begin
                        r_rsp_pend <= 1'b0;
                        r_state    <= P_CMD;
                    end
                end
                default: r_state <= P_CMD;
            endcase
        end
    end

    assign o_rx_rinc    = w_pop;
    assign o_ctrl_we    = w_pop & (r_state == P_DATA) & (r_addr == CTRL_ADDR);
    assign o_ctrl_wdata = i_rx_rdata;
    assign o_reg_addr   = r_reg_addr;
    assign o_reg_wdata  = r_reg_wdata;
    assign o_reg_we     = r_reg_we;
    assign o_rsp_pend   = r_rsp_pend;
    assign o_rsp_addr   = r_addr;
    assign o_rsp_data   = r_rsp_data;
    assign o_cmd_err    = r_cmd_err;

endmodule
`default_nettype wire

// File: rtl/cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : cmd_sched
// Brief    : Command scheduler top: parser, CTRL register and tx arbiter that
//            serialises read responses and 16-bit pixel words to the host.
// Revision : 1.0
// ============================================================================
module cmd_sched
    import cmd_sched_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst,
    cmd_sched_if.master  bus
);

    logic [2:0]  r_state;
    logic [7:0]  r_ctrl;
    logic [15:0] r_pix;

    logic        w_ctrl_we;
    logic [7:0]  w_ctrl_wdata;
    logic        w_rsp_pend;
    logic [3:0]  w_rsp_addr;
    logic [7:0]  w_rsp_data;
    logic        w_rsp_done;
    logic        w_tx_winc;
    logic        w_pix_en;
    logic        w_pix_ready;
    logic [7:0]  w_tx_wdata;

    cmd_parse u_parse (
        .clk          (clk),
        .rst          (rst),
        .i_rx_rdata   (bus.rx_rdata),
        .i_rx_rempty  (bus.rx_rempty),
        .o_rx_rinc    (bus.rx_rinc),
        .i_ctrl       (r_ctrl),
        .i_reg_rdata  (bus.reg_rdata),
        .i_rsp_done   (w_rsp_done),
        .o_reg_addr   (bus.reg_addr),
        .o_reg_wdata  (bus.reg_wdata),
        .o_reg_we     (bus.reg_we),
        .o_ctrl_we    (w_ctrl_we),
        .o_ctrl_wdata (w_ctrl_wdata),
        .o_rsp_pend   (w_rsp_pend),
        .o_rsp_addr   (w_rsp_addr),
        .o_rsp_data   (w_rsp_data),
        .o_cmd_err    (bus.cmd_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ctrl <= 8'h00;
        else if (w_ctrl_we)
            r_ctrl <= w_ctrl_wdata;
    end

    assign w_pix_en    = r_ctrl[CTRL_PIX_EN_BIT];
    assign w_tx_winc   = (r_state != T_IDLE) & ~bus.tx_wfull;
    assign w_rsp_done  = (r_state == T_RSP1) & w_tx_winc;
    // responses win at T_IDLE; a pixel is only taken when none is pending
    assign w_pix_ready = (r_state == T_IDLE) & ~w_rsp_pend & w_pix_en & bus.pix_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= T_IDLE;
            r_pix   <= 16'h0000;
        end else begin
            case (r_state)
                T_IDLE: begin
                    if (w_rsp_pend) begin
                        r_state <= T_RSP0;
                    end else if (w_pix_ready) begin
                        r_pix   <= bus.pix_data;
                        r_state <= T_PIX0;
                    end
                end
                T_RSP0: if (w_tx_winc) r_state <= T_RSP1;
                T_RSP1: if (w_tx_winc) r_state <= T_IDLE;
                T_PIX0: if (w_tx_winc) r_state <= T_PIX1;
                T_PIX1: if (w_tx_winc) r_state <= T_IDLE;
                default: r_state <= T_IDLE;
            endcase
        end
    end

    always_comb begin
        w_tx_wdata = 8'h00;
        case (r_state)
            T_RSP0:  w_tx_wdata = rsp_header(w_rsp_addr);
            T_RSP1:  w_tx_wdata = w_rsp_data;
            T_PIX0:  w_tx_wdata = r_pix[7:0];
            T_PIX1:  w_tx_wdata = r_pix[15:8];
            default: w_tx_wdata = 8'h00;
        endcase
    end

    assign bus.tx_wdata  = w_tx_wdata;
    assign bus.tx_winc   = w_tx_winc;
    assign bus.pix_ready = w_pix_ready;
    assign bus.pix_en    = w_pix_en;

endmodule
`default_nettype wire

// File: doc/cmd_sched.md
CMD_SCHED -- requirements
Module: cmd_sched

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 rx_rdata  input  8  head byte of host->FPGA FIFO (first-word fall-through, valid while rx_rempty low).
REQ-004 rx_rempty  input  1  host->FPGA FIFO empty.
REQ-005 rx_rinc  output  1  pop host->FPGA FIFO this cycle.
REQ-006 tx_wdata  output  8  byte to FPGA->host FIFO.
REQ-007 tx_wfull  input  1  FPGA->host FIFO full.
REQ-008 tx_winc  output  1  push tx_wdata this cycle.
REQ-009 reg_addr  output  4  external register address.
REQ-010 reg_wdata  output  8  external register write data.
REQ-011 reg_we  output  1  external register write strobe, one cycle.
REQ-012 reg_rdata  input  8  external register read data, combinational from reg_addr.
REQ-013 pix_data  input  16  pixel word from CCD readout.
REQ-014 pix_valid  input  1  pix_data valid.
REQ-015 pix_ready  output  1  pixel word accepted this cycle (valid&ready handshake).
REQ-016 pix_en  output  1  stream enable, CTRL[0].
REQ-017 cmd_err  output  1  one-cycle pulse on malformed command byte.

Function
REQ-018 Command byte: bit7=1 write, 0 read; bits6:4 reserved, must be 000; bits3:0 address.
REQ-019 Parser states: P_CMD, P_DATA, P_WAIT; rx_rinc = (state in P_CMD/P_DATA) & ~rx_rempty & ~(P_CMD & rsp_pend).
REQ-020 P_CMD, reserved bits nonzero: byte popped, discarded, cmd_err pulsed next cycle, stay P_CMD.
REQ-021 P_CMD, write cmd popped: latch addr, go P_DATA.
REQ-022 P_DATA, byte popped: addr 0 -> CTRL updated next edge; addr 1..15 -> reg_addr/reg_wdata driven, reg_we high exactly one cycle after pop; return P_CMD.
REQ-023 P_CMD, read cmd popped: latch addr, set rsp_pend, go P_WAIT; P_WAIT -> P_CMD when response byte 1 written; no rx pops while rsp_pend.
REQ-024 Read data captured from reg_rdata (or CTRL for addr 0) in the cycle after pop, held in rsp_data.
REQ-025 Read response = 2 bytes: 0xA0|addr, then rsp_data.
REQ-026 Tx arbiter states: T_IDLE, T_RSP0, T_RSP1, T_PIX0, T_PIX1.
REQ-027 T_IDLE: rsp_pend -> T_RSP0 (response priority); else pix_en & pix_valid -> pix_ready one cycle, pixel latched, T_PIX0.
REQ-028 tx_winc = state in T_RSP0/T_RSP1/T_PIX0/T_PIX1 & ~tx_wfull; state advances only on cycles tx_winc high.
REQ-029 Pixel sent LSB (T_PIX0) then MSB (T_PIX1); packets never interleaved; tx_wfull stalls hold state and tx_wdata.
REQ-030 Response pending during a pixel packet waits for T_PIX1 completion, then wins at T_IDLE.
REQ-031 pix_ready never high unless pix_en high and arbiter in T_IDLE with rsp_pend low.
REQ-032 Clearing pix_en mid-packet finishes current pixel; no further pix_ready.
REQ-033 Write to addr 0 while a read of addr 0 is pending impossible (parser stalled); reads of addr 0 return CTRL as last written.
REQ-034 Throughput: one byte per cycle when tx_wfull low; pixel rate max one word per 3 cycles (T_IDLE, T_PIX0, T_PIX1).

Reset
REQ-035 rst high: parser P_CMD, arbiter T_IDLE, rsp_pend 0, CTRL 0x00 (pix_en 0).
REQ-036 rst high: rx_rinc, tx_winc, reg_we, pix_ready, cmd_err 0; tx_wdata, reg_addr, reg_wdata 0.
REQ-037 rst mid-packet abandons partial response/pixel; no further bytes of it emitted.

Structure
REQ-038 Package cmd_sched_pkg: parser/arbiter state encodings, RSP_HDR 0xA0, CTRL address 0, command bit positions.
REQ-039 One sub-module cmd_parse (parser FSM, REQ-018..024); arbiter and CTRL in cmd_sched top.

Verification
REQ-040 Push 0x83,0x5A, FIFOs idle -> reg_we one cycle, reg_addr 3, reg_wdata 0x5A.
REQ-041 Push 0x80,0x01 then 0x00 -> pix_en 1; tx emits 0xA0,0x01.
REQ-042 reg_rdata 0x3C at addr 7, push 0x07 with tx_wfull high 10 cycles -> no tx_winc while full, then 0xA7,0x3C.
REQ-043 pix_en 1, pix_valid continuous 0x1234,0xABCD -> tx 0x34,0x12,0xCD,0xAB; pix_ready one cycle per word.
REQ-044 Read cmd arrives during T_PIX0 -> pixel MSB emitted before 0xAx header; no interleave.
REQ-045 Push 0x90 -> cmd_err one pulse, no reg_we, no tx; following 0x82,0x11 handled normally.
